// File: rtl/st2_cart_loader_if.sv
// ioctl download stream in, cartridge bram write port and load status out.
interface st2_cart_loader_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        cart_we;
  logic [15:0] cart_addr;
  logic [7:0]  cart_d;
  logic        cpu_hold;
  logic        cart_valid;
  logic        cart_error;
  logic [4:0]  blocks_loaded;

  // Loader side
  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output cart_we, cart_addr, cart_d, cpu_hold, cart_valid, cart_error, blocks_loaded
  );

  // HPS / host side
  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  cart_we, cart_addr, cart_d, cpu_hold, cart_valid, cart_error, blocks_loaded
  );
endinterface

// File: rtl/st2_cart_loader.sv
// Cartridge loader: raw binary at a fixed base, or an ST2 container whose
// 256-byte data blocks are scattered to pages named in the header table.
module st2_cart_loader #(
  parameter logic [7:0]  RAW_INDEX  = 8'h01,
  parameter logic [15:0] RAW_BASE   = 16'h0400,
  parameter int          MAX_BLOCKS = 16,
  parameter logic [7:0]  MIN_PAGE   = 8'h04
) (
  input logic clk,
  input logic reset,
  st2_cart_loader_if.slave bus
);
  localparam int         PTW     = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1;
  localparam logic [7:0] N_MAX   = 8'(MAX_BLOCKS + 1);
  localparam logic [7:0] PT_LAST = 8'(64 + MAX_BLOCKS - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RAW  = 3'd1;
  localparam logic [2:0] S_HDR  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  logic [2:0]  state;
  logic        dl_q;
  logic        bad;
  logic [7:0]  nblk;          // header block count minus one
  logic [7:0]  page_tbl [MAX_BLOCKS];
  logic        we_r, hold_r, valid_r, err_r;
  logic [15:0] addr_r;
  logic [7:0]  d_r;
  logic [4:0]  blocks_r;

  logic        rise, fall;
  logic [7:0]  off8;
  logic        hdr_wr, hdr_bad;
  logic [PTW-1:0] pt_idx;
  logic [4:0]  blk;
  logic        data_wr, blk_in, page_ok, data_we, data_bad, blk_done;
  logic [7:0]  blk_page;
  logic        bad_nxt;
  logic [4:0]  bl_nxt;

  assign rise = bus.ioctl_download & ~dl_q;
  assign fall = ~bus.ioctl_download & dl_q;
  assign off8 = bus.ioctl_addr[7:0];

  assign hdr_wr = (state == S_HDR) && bus.ioctl_wr && (bus.ioctl_addr[24:8] == 17'd0);
  assign pt_idx = PTW'(off8 - 8'd64);

  // Header checks: "RCA2" magic at 0..3, block count N-1 in 1..MAX_BLOCKS at 4
  always_comb begin
    hdr_bad = 1'b0;
    if (hdr_wr) begin
      case (off8)
        8'd0:    hdr_bad = (bus.ioctl_dout != 8'h52);
        8'd1:    hdr_bad = (bus.ioctl_dout != 8'h43);
        8'd2:    hdr_bad = (bus.ioctl_dout != 8'h41);
        8'd3:    hdr_bad = (bus.ioctl_dout != 8'h32);
        8'd4:    hdr_bad = (bus.ioctl_dout < 8'd2) || (bus.ioctl_dout > N_MAX);
        default: hdr_bad = 1'b0;
      endcase
    end
  end

  // Data block decode; blk wraps to 31 for offsets whose bits [12:8] are zero
  assign blk      = bus.ioctl_addr[12:8] - 5'd1;
  assign data_wr  = (state == S_DATA) && bus.ioctl_wr && (bus.ioctl_addr[24:8] != 17'd0);
  assign blk_in   = ({3'd0, blk} < nblk);
  assign blk_page = page_tbl[blk[PTW-1:0]];
  assign page_ok  = (blk_page >= MIN_PAGE);
  assign data_we  = data_wr && blk_in && page_ok;
  assign data_bad = data_wr && blk_in && !page_ok;
  assign blk_done = data_we && (off8 == 8'hFF);

  // Same-cycle byte is folded in before the end-of-download decision
  assign bad_nxt = bad | hdr_bad | data_bad;
  assign bl_nxt  = blocks_r + {4'd0, blk_done};

  // Page table latch; deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (!reset && hdr_wr && off8 >= 8'd64 && off8 <= PT_LAST)
      page_tbl[pt_idx] <= bus.ioctl_dout;
  end

  // Load sequencing, write port and status
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      // Track the live level so a download still high after reset is not
      // mistaken for a new one
      dl_q     <= bus.ioctl_download;
      bad      <= 1'b0;
      nblk     <= 8'd0;
      we_r     <= 1'b0;
      addr_r   <= 16'd0;
      d_r      <= 8'd0;
      hold_r   <= 1'b0;
      valid_r  <= 1'b0;
      err_r    <= 1'b0;
      blocks_r <= 5'd0;
    end else begin
      dl_q <= bus.ioctl_download;
      we_r <= 1'b0;
      if (rise) begin
        state    <= (bus.ioctl_index == RAW_INDEX) ? S_RAW : S_HDR;
        bad      <= 1'b0;
        hold_r   <= 1'b1;
        valid_r  <= 1'b0;
        err_r    <= 1'b0;
        blocks_r <= 5'd0;
      end else begin
        case (state)
          S_RAW: begin
            if (bus.ioctl_wr && bus.ioctl_addr < 25'h800) begin
              we_r   <= 1'b1;
              addr_r <= RAW_BASE + bus.ioctl_addr[15:0];
              d_r    <= bus.ioctl_dout;
            end
            if (fall) state <= S_DONE;
          end
          S_HDR: begin
            if (hdr_wr) begin
              bad <= bad_nxt;
              if (off8 == 8'd4) nblk <= bus.ioctl_dout - 8'd1;
              if (off8 == 8'hFF) state <= bad_nxt ? S_ERR : S_DATA;
            end
            if (fall) state <= S_ERR;
          end
          S_DATA: begin
            if (data_we) begin
              we_r   <= 1'b1;
              addr_r <= {blk_page, off8};
              d_r    <= bus.ioctl_dout;
            end
            bad      <= bad_nxt;
            blocks_r <= bl_nxt;
            if (fall) state <= (bad_nxt || ({3'd0, bl_nxt} < nblk)) ? S_ERR : S_DONE;
          end
          S_DONE: begin
            valid_r <= 1'b1;
            hold_r  <= 1'b0;
            state   <= S_IDLE;
          end
          S_ERR: begin
            err_r  <= 1'b1;
            hold_r <= 1'b0;
            state  <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.cart_we       = we_r;
  assign bus.cart_addr     = addr_r;
  assign bus.cart_d        = d_r;
  assign bus.cpu_hold      = hold_r;
  assign bus.cart_valid    = valid_r;
  assign bus.cart_error    = err_r;
  assign bus.blocks_loaded = blocks_r;
endmodule

// File: tb/tb_st2_cart_loader.sv
// Randomized bench for st2_cart_loader against an image-level reference model.
module tb_st2_cart_loader;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  st2_cart_loader_if bus();
  st2_cart_loader dut (.clk(clk), .reset(reset), .bus(bus));

  int checks, errors;
  logic [7:0]  img [0:8191];
  logic [23:0] exp_q[$], got_q[$];
  bit          exp_valid, exp_err, exp_early;
  int          exp_blocks;
  logic        hold_rise, hold_mid;
  logic [1:0]  mid_st;
  logic        last_wr;
  logic [7:0]  last_dout;

  // Collect cart writes; each must carry the byte offered one cycle earlier
  always @(negedge clk) begin
    if (bus.cart_we === 1'b1) begin
      checks++;
      if (last_wr !== 1'b1 || bus.cart_d !== last_dout) begin
        errors++;
        $display("FAIL latency: cart_we addr=%h d=%h, prior cycle wr=%b dout=%h", bus.cart_addr, bus.cart_d, last_wr, last_dout);
      end
      got_q.push_back({bus.cart_addr, bus.cart_d});
    end
    last_wr   = bus.ioctl_wr & ~reset;
    last_dout = bus.ioctl_dout;
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  // Reference: what a whole image of len bytes should produce
  function automatic void model(input logic [7:0] idx, input int len, input bit fwl);
    int nb, blk;
    logic [7:0] pg;
    bit bad;
    exp_q.delete();
    exp_blocks = 0;
    exp_early = 0;
    if (idx == 8'h01) begin
      for (int off = 0; off < len; off++)
        if (off < 'h800) exp_q.push_back({16'h0400 + 16'(off), img[off]});
      exp_valid = 1; exp_err = 0;
      return;
    end
    bad = 0;
    nb = int'(img[4]) - 1;
    if (img[0] != 8'h52 || img[1] != 8'h43 || img[2] != 8'h41 || img[3] != 8'h32) bad = 1;
    if (nb < 1 || nb > 16) bad = 1;
    if (bad || len < 256) begin
      exp_early = bad && (len > 256 || (len == 256 && !fwl));
      exp_valid = 0; exp_err = 1;
      return;
    end
    for (int off = 256; off < len; off++) begin
      blk = off / 256 - 1;
      if (blk < nb) begin
        pg = img[64 + blk];
        if (pg >= 8'h04) exp_q.push_back({pg, 8'(off % 256), img[off]});
        else bad = 1;
      end
    end
    for (int b = 0; b < nb; b++)
      if (img[64 + b] >= 8'h04 && len >= (b + 2) * 256) exp_blocks++;
    exp_err = bad || (exp_blocks < nb);
    exp_valid = !exp_err;
  endfunction

  function automatic int n_mismatch();
    int m = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) m++;
    return m;
  endfunction

  function automatic logic [7:0] status();
    return {bus.cart_valid, bus.cart_error, bus.cpu_hold, bus.blocks_loaded};
  endfunction

  task automatic hdr_init(input logic [7:0] n);
    for (int i = 0; i < 4096; i++) img[i] = 8'($urandom);
    img[0] = 8'h52; img[1] = 8'h43; img[2] = 8'h41; img[3] = 8'h32;
    img[4] = n;
  endtask

  task automatic run_load(input logic [7:0] idx, input int len, input int gap_max, input bit fwl);
    got_q.delete();
    bus.ioctl_index = idx;
    bus.ioctl_download = 1'b1;
    step();
    hold_rise = bus.cpu_hold;
    for (int off = 0; off < len; off++) begin
      bus.ioctl_wr = 1'b1;
      bus.ioctl_addr = 25'(off);
      bus.ioctl_dout = img[off];
      if (fwl && off == len - 1) bus.ioctl_download = 1'b0;
      step();
      bus.ioctl_wr = 1'b0;
      if (off != len - 1) repeat ($urandom_range(0, gap_max)) step();
    end
    if (bus.ioctl_download) begin
      bus.ioctl_download = 1'b0;
      step();
    end
    hold_mid = bus.cpu_hold;
    mid_st = {bus.cart_valid, bus.cart_error};
    step();
  endtask

  // Shared tail of the per-test checks is written inline in each task
  task automatic test_reset();
    checks++;
    if (bus.cart_we !== 1'b0) begin errors++; $display("FAIL reset cart_we: got %b want 0", bus.cart_we); end
    checks++;
    if (bus.cart_addr !== 16'h0) begin errors++; $display("FAIL reset cart_addr: got %h want 0000", bus.cart_addr); end
    checks++;
    if (bus.cart_d !== 8'h0) begin errors++; $display("FAIL reset cart_d: got %h want 00", bus.cart_d); end
    checks++;
    if (status() !== 8'h0) begin errors++; $display("FAIL reset status: got %h want 00", status()); end
  endtask

  task automatic test_idle_wr();
    got_q.delete();
    for (int i = 0; i < 4; i++) begin
      bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'(i); bus.ioctl_dout = 8'(i + 1);
      step();
    end
    bus.ioctl_wr = 1'b0;
    step(); step();
    checks++;
    if (got_q.size() != 0 || status() !== 8'h0) begin
      errors++; $display("FAIL idle_wr: writes %0d status %h want 0 00", got_q.size(), status());
    end
  endtask

  task automatic test_raw_basic();
    img[0] = 8'hAA; img[1] = 8'hBB; img[2] = 8'hCC; img[3] = 8'hDD;
    run_load(8'h01, 4, 0, 0);
    model(8'h01, 4, 0);
    checks++;
    if (hold_rise !== 1'b1 || hold_mid !== 1'b1 || mid_st !== 2'b00) begin
      errors++; $display("FAIL raw_basic timing: rise %b mid %b/%b want 1 1/00", hold_rise, hold_mid, mid_st);
    end
    checks++;
    if (got_q.size() != 4 || got_q[0] !== 24'h0400AA || got_q[3] !== 24'h0403DD) begin
      errors++; $display("FAIL raw_basic writes: got %0d want 4 (0400AA..0403DD)", got_q.size());
    end
    checks++;
    if (status() !== 8'b1000_0000) begin errors++; $display("FAIL raw_basic status: got %h want 80", status()); end
  endtask

  task automatic test_raw_limit();
    for (int i = 0; i < 'h806; i++) img[i] = 8'($urandom);
    run_load(8'h01, 'h806, 1, 1);
    model(8'h01, 'h806, 1);
    checks++;
    if (got_q.size() != exp_q.size() || n_mismatch() != 0) begin
      errors++; $display("FAIL raw_limit writes: got %0d (%0d differ) want %0d", got_q.size(), n_mismatch(), exp_q.size());
    end
    checks++;
    if (status() !== {exp_valid, exp_err, 1'b0, 5'(exp_blocks)}) begin
      errors++; $display("FAIL raw_limit status: got %h want %h", status(), {exp_valid, exp_err, 1'b0, 5'(exp_blocks)});
    end
  endtask

  task automatic test_st2(input string nm, input logic [7:0] n, input logic [7:0] p0, input logic [7:0] p1,
                          input logic [7:0] magic3, input int len);
    hdr_init(n);
    img[3] = magic3;
    img[64] = p0; img[65] = p1;
    for (int i = 256; i < 512; i++) img[i] = 8'h11;
    for (int i = 512; i < 768; i++) img[i] = 8'h22;
    run_load(8'h00, len, 1, 0);
    model(8'h00, len, 0);
    checks++;
    if (hold_rise !== 1'b1 || {hold_mid, mid_st} !== (exp_early ? 3'b001 : 3'b100)) begin
      errors++; $display("FAIL %s timing: rise %b mid %b/%b early=%0d", nm, hold_rise, hold_mid, mid_st, exp_early);
    end
    checks++;
    if (got_q.size() != exp_q.size() || n_mismatch() != 0) begin
      errors++; $display("FAIL %s writes: got %0d (%0d differ) want %0d", nm, got_q.size(), n_mismatch(), exp_q.size());
    end
    checks++;
    if (status() !== {exp_valid, exp_err, 1'b0, 5'(exp_blocks)}) begin
      errors++; $display("FAIL %s status: got %h want %h", nm, status(), {exp_valid, exp_err, 1'b0, 5'(exp_blocks)});
    end
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 7; it++) begin
      int n, len;
      bit fwl;
      n = $urandom_range(2, 5);
      hdr_init(8'(n));
      for (int b = 0; b < 16; b++)
        img[64 + b] = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(4, 255));
      case ($urandom_range(0, 2))
        0: len = n * 256;
        1: len = (n + 1) * 256;
        default: len = $urandom_range(256, n * 256 - 1);
      endcase
      fwl = 1'($urandom_range(0, 1));
      if (it == 5) begin img[4] = 8'd18; len = 768; end
      if (it == 6) begin img[4] = 8'd1; len = 768; end
      run_load(8'h00, len, 0, fwl);
      model(8'h00, len, fwl);
      checks++;
      if ({hold_mid, mid_st} !== (exp_early ? 3'b001 : 3'b100)) begin
        errors++; $display("FAIL b2b[%0d] mid: got %b/%b early=%0d", it, hold_mid, mid_st, exp_early);
      end
      checks++;
      if (got_q.size() != exp_q.size() || n_mismatch() != 0) begin
        errors++; $display("FAIL b2b[%0d] writes: got %0d (%0d differ) want %0d", it, got_q.size(), n_mismatch(), exp_q.size());
      end
      checks++;
      if (status() !== {exp_valid, exp_err, 1'b0, 5'(exp_blocks)}) begin
        errors++; $display("FAIL b2b[%0d] status: got %h want %h", it, status(), {exp_valid, exp_err, 1'b0, 5'(exp_blocks)});
      end
    end
  endtask

  task automatic test_reset_mid_load();
    hdr_init(8'd3);
    img[64] = 8'h04; img[65] = 8'h0A;
    bus.ioctl_index = 8'h00;
    bus.ioctl_download = 1'b1;
    step();
    for (int off = 0; off < 768; off++) begin
      bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'(off); bus.ioctl_dout = img[off];
      if (off == 400) reset = 1'b1;
      step();
      if (off == 400) begin
        got_q.delete();
        reset = 1'b0;
        checks++;
        if (bus.cart_we !== 1'b0 || bus.cart_addr !== 16'h0 || bus.cart_d !== 8'h0 || status() !== 8'h0) begin
          errors++; $display("FAIL rst_mid outputs: we %b addr %h d %h status %h want all 0", bus.cart_we, bus.cart_addr, bus.cart_d, status());
        end
      end
    end
    bus.ioctl_wr = 1'b0;
    bus.ioctl_download = 1'b0;
    repeat (4) step();
    checks++;
    if (got_q.size() != 0 || status() !== 8'h0) begin
      errors++; $display("FAIL rst_mid after: writes %0d status %h want 0 00", got_q.size(), status());
    end
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
    run_load(8'h01, 16, 1, 0);
    model(8'h01, 16, 0);
    checks++;
    if (got_q.size() != exp_q.size() || n_mismatch() != 0 || status() !== 8'h80) begin
      errors++; $display("FAIL rst_mid reload: writes %0d (%0d differ) want %0d, status %h want 80", got_q.size(), n_mismatch(), exp_q.size(), status());
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1;
    bus.ioctl_download = 1'b0; bus.ioctl_index = 8'h00; bus.ioctl_wr = 1'b0;
    bus.ioctl_addr = 25'd0; bus.ioctl_dout = 8'h00;
    last_wr = 1'b0; last_dout = 8'h00;
    repeat (3) step();
    test_reset();
    reset = 1'b0;
    step();
    test_idle_wr();
    test_raw_basic();
    test_raw_limit();
    test_st2("st2_basic", 8'd3, 8'h04, 8'h0A, 8'h32, 768);
    checks++;
    if (got_q.size() != 512 || status() !== 8'b1000_0010) begin
      errors++; $display("FAIL st2_basic count: writes %0d status %h want 512 82", got_q.size(), status());
    end
    test_st2("bad_magic", 8'd3, 8'h04, 8'h0A, 8'h33, 768);
    test_st2("low_page", 8'd3, 8'h02, 8'h0A, 8'h32, 768);
    test_st2("trunc_data", 8'd3, 8'h04, 8'h0A, 8'h32, 356);
    test_st2("trunc_hdr", 8'd3, 8'h04, 8'h0A, 8'h32, 100);
    test_back_to_back();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
